// File: rtl/sort_pkg.sv
// Shared definitions for the insertion sorter and its feeder: default sizes,
// feeder state encoding and index width.
package sort_pkg;

   localparam int SORT_N  = 8;
   localparam int SORT_DW = 8;
   localparam int SORT_IW = $clog2(SORT_N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      PUSH  = 2'd2,
      GAP   = 2'd3
   } sort_state_e;

endpackage

// File: rtl/sort_feeder.sv
// Feeds one packed word into the insertion sorter element by element and
// captures the sorted outputs. Optional SORT_FEED_MINMAX_EN adds min/max/span.
module sort_feeder
   import sort_pkg::*;
#(
   parameter int DW = SORT_DW,
   parameter int N  = SORT_N
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [N*DW-1:0] data_word,
   output logic            busy,
   output logic            done,
   output logic [N*DW-1:0] result,
   output logic            sort_clear,
   output logic            sort_en,
   output logic [DW-1:0]   sort_in,
   input  logic [N*DW-1:0] small_flat,
`ifdef SORT_FEED_MINMAX_EN
   output logic [DW-1:0]   min_val,
   output logic [DW-1:0]   max_val,
   output logic [DW-1:0]   span,
`endif
   output sort_state_e     state_dbg
);

   // Handshake: start is taken only in IDLE (busy low); busy stays high for
   // the whole job and done pulses for one cycle when result is refreshed.
   // abort drops a running job without touching result.

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   sort_state_e     state, state_next;
   logic [IW-1:0]   index;
   logic [IW-1:0]   push_idx;
   logic [N*DW-1:0] data_q;
   logic            last;
   logic            accept;
   logic            capture;
   logic            busy_d, clear_d, en_d, done_d;
   logic [DW-1:0]   sort_in_d;

   assign last      = (index == IW'(N - 1));
   assign accept    = (state == IDLE) && start && !abort;
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (state != IDLE && abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_next = CLEAR;
            CLEAR:   state_next = PUSH;
            PUSH:    state_next = GAP;
            GAP:     state_next = last ? IDLE : PUSH;
            default: state_next = IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state and registered, so each control
   // line is high exactly in the cycle its state occupies.
   always_comb begin
      capture   = (state == GAP) && last && !abort;
      busy_d    = (state_next != IDLE);
      clear_d   = (state_next == CLEAR);
      en_d      = (state_next == PUSH);
      done_d    = capture;
      push_idx  = (state == GAP) ? index + 1'b1 : index;
      sort_in_d = sort_in;
      if (state_next == PUSH) sort_in_d = data_q[DW*push_idx +: DW];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         sort_clear <= 1'b0;
         sort_en    <= 1'b0;
         sort_in    <= '0;
         result     <= '0;
         index      <= '0;
         data_q     <= '0;
      end else begin
         busy       <= busy_d;
         done       <= done_d;
         sort_clear <= clear_d;
         sort_en    <= en_d;
         sort_in    <= sort_in_d;
         if (accept) begin
            data_q <= data_word;
            index  <= '0;
         end else if (state == GAP && !last && !abort) begin
            index <= index + 1'b1;
         end
         if (capture) result <= small_flat;
      end
   end

`ifdef SORT_FEED_MINMAX_EN
   // Sorter outputs are ascending, so the top element never underflows span.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         min_val <= '0;
         max_val <= '0;
         span    <= '0;
      end else if (capture) begin
         min_val <= small_flat[DW-1:0];
         max_val <= small_flat[N*DW-1 -: DW];
         span    <= small_flat[N*DW-1 -: DW] - small_flat[DW-1:0];
      end
   end
`endif

endmodule
